// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one valid/ready adder between N_REQ requesters.
// An in-order tag FIFO steers each returning sum to the requester that issued it.
module adder_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  output logic [N_REQ-1:0]       req_rdy,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   a_vld,
  input  logic                   a_rdy,
  output logic [WIDTH-1:0]       a_data,
  output logic                   b_vld,
  input  logic                   b_rdy,
  output logic [WIDTH-1:0]       b_data,
  input  logic                   sum_vld,
  output logic                   sum_rdy,
  input  logic [WIDTH:0]         sum_data,
  output logic [N_REQ-1:0]       rsp_vld,
  input  logic [N_REQ-1:0]       rsp_rdy,
  output logic [WIDTH:0]         rsp_data
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW  = $clog2(TAG_DEPTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t           state;
  logic             a_done;
  logic             b_done;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   tag_mem [TAG_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             a_fire;
  logic             b_fire;
  logic             completing;
  logic             slot_free;
  logic             fifo_full;
  logic             fifo_empty;
  logic             grant;
  logic             pop;
  logic [IDW-1:0]   head;

  // Round-robin search starting just after the last winner; later hits never override the first.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        winner = idx;
      end else begin
        winner = winner;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == winner) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end else begin
        sel_a = sel_a;
        sel_b = sel_b;
      end
    end
  end

  assign a_vld      = ~rst & (state == ISSUE) & ~a_done;
  assign b_vld      = ~rst & (state == ISSUE) & ~b_done;
  assign a_data     = a_reg;
  assign b_data     = b_reg;
  assign a_fire     = a_vld & a_rdy;
  assign b_fire     = b_vld & b_rdy;
  assign completing = (a_done | a_fire) & (b_done | b_fire);
  assign slot_free  = (state == IDLE) | ((state == ISSUE) & completing);
  // Fullness is judged before any same-cycle pop so push never depends on the return path.
  assign fifo_full  = (count == CW'(TAG_DEPTH));
  assign fifo_empty = (count == CW'(0));
  assign grant      = ~rst & slot_free & ~fifo_full & found;
  assign head       = tag_mem[rd_ptr];
  assign sum_rdy    = ~rst & ~fifo_empty & rsp_rdy[head];
  assign pop        = sum_vld & sum_rdy;
  assign rsp_data   = (~rst & ~fifo_empty) ? sum_data : '0;

  // Grant strobe to the winner and result valid to the head-tag owner.
  always_comb begin
    req_rdy = '0;
    rsp_vld = '0;
    if (grant) begin
      req_rdy[winner] = 1'b1;
    end else begin
      req_rdy = '0;
    end
    if (~rst & ~fifo_empty) begin
      rsp_vld[head] = sum_vld;
    end else begin
      rsp_vld = '0;
    end
  end

  // Issue FSM, operand register, round-robin pointer and tag FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      ptr    <= IDW'(N_REQ - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      if (grant) begin
        state  <= ISSUE;
        a_reg  <= sel_a;
        b_reg  <= sel_b;
        a_done <= 1'b0;
        b_done <= 1'b0;
        ptr    <= winner;
      end else if (state == ISSUE) begin
        if (completing) begin
          state  <= IDLE;
          a_done <= 1'b0;
          b_done <= 1'b0;
        end else begin
          if (a_fire) a_done <= 1'b1;
          if (b_fire) b_done <= 1'b1;
        end
      end
      if (grant) begin
        tag_mem[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (grant & ~pop) begin
        count <= count + CW'(1);
      end else if (pop & ~grant) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter; a queue-based adder model stands in for the shared adder.
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld, req_rdy;
  logic [15:0] req_a, req_b;
  logic        a_vld, a_rdy, b_vld, b_rdy;
  logic [3:0]  a_data, b_data;
  logic        sum_vld, sum_rdy;
  logic [4:0]  sum_data, rsp_data;
  logic [3:0]  rsp_vld, rsp_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] aq[$];
  logic [3:0] bq[$];

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
  } vec_t;

  vec_t       tbl [5];
  logic [3:0] exp_gnt [6];
  logic [3:0] exp_rsp [4];
  logic [4:0] exp_sum [4];

  adder_share_arbiter #(.N_REQ(4), .WIDTH(4), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_data(b_data),
    .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_data(sum_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // One clock: sample handshakes before the edge, update the adder model after it.
  task automatic step();
    logic fa, fb, fs, r;
    logic [3:0] ad, bd, x, y;
    fa = a_vld & a_rdy; fb = b_vld & b_rdy; fs = sum_vld & sum_rdy; r = rst;
    ad = a_data; bd = b_data;
    @(posedge clk); #1;
    if (r) begin
      aq.delete(); bq.delete(); sum_vld = 1'b0; sum_data = 5'd0;
    end else begin
      if (fa) aq.push_back(ad);
      if (fb) bq.push_back(bd);
      if (fs) sum_vld = 1'b0;
      if (!sum_vld && aq.size() > 0 && bq.size() > 0) begin
        x = aq.pop_front(); y = bq.pop_front();
        sum_data = {1'b0, x} + {1'b0, y};
        sum_vld  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    req_vld = 4'h0; a_rdy = 1'b1; b_rdy = 1'b1; rsp_rdy = 4'hF;
    repeat (n) step();
  endtask

  initial begin
    tbl[0] = '{2, 4'd9,  4'd8,  5'd17};
    tbl[1] = '{0, 4'd15, 4'd15, 5'd30};
    tbl[2] = '{3, 4'd0,  4'd0,  5'd0};
    tbl[3] = '{1, 4'd7,  4'd1,  5'd8};
    tbl[4] = '{2, 4'd10, 4'd6,  5'd16};
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_rsp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_sum = '{5'd6, 5'd8, 5'd10, 5'd12};

    rst = 1'b1; req_vld = 4'hF; req_a = 16'h0; req_b = 16'h0;
    a_rdy = 1'b1; b_rdy = 1'b1; rsp_rdy = 4'hF; sum_vld = 1'b0; sum_data = 5'd0;

    // Reset: outputs quiet during and after reset.
    @(negedge clk); #1;
    chk("rst_req_rdy", req_rdy, 4'h0);
    chk("rst_ab_vld", {a_vld, b_vld}, 2'b00);
    step(); step();
    rst = 1'b0; req_vld = 4'h0; #1;
    chk("post_rst_valids", {a_vld, b_vld, sum_rdy, rsp_vld, req_rdy}, 11'h0);
    chk("post_rst_data", {a_data, b_data, rsp_data}, 13'h0);

    // Round-robin with all requesters valid.
    req_vld = 4'hF; req_a = 16'h4321; req_b = 16'h8765;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_grant", req_rdy, exp_gnt[c]);
      if (c >= 2) begin
        chk("rr_rsp_vld", rsp_vld, exp_rsp[c-2]);
        chk("rr_rsp_data", rsp_data, exp_sum[c-2]);
      end
      step();
    end
    drain(6);

    // Single operations from the vector table.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << tbl[i].idx;
      req_a = 16'h0; req_b = 16'h0;
      req_a[tbl[i].idx*4 +: 4] = tbl[i].a;
      req_b[tbl[i].idx*4 +: 4] = tbl[i].b;
      req_vld = oh; #1;
      chk("vec_grant", req_rdy, oh);
      step();
      req_vld = 4'h0; #1;
      chk("vec_ab_vld", {a_vld, b_vld}, 2'b11);
      chk("vec_a_data", a_data, tbl[i].a);
      chk("vec_b_data", b_data, tbl[i].b);
      step(); #1;
      chk("vec_rsp_vld", rsp_vld, oh);
      chk("vec_rsp_data", rsp_data, tbl[i].sum);
      step(); #1;
      chk("vec_rsp_clear", rsp_vld, 4'h0);
      step();
    end

    // Split operand handshake: b stalls three cycles.
    req_a = 16'h0; req_b = 16'h0;
    req_a[11:8] = 4'd3; req_b[11:8] = 4'd5; req_a[7:4] = 4'd6; req_b[7:4] = 4'd1;
    req_vld = 4'b0100; a_rdy = 1'b1; b_rdy = 1'b0; #1;
    chk("split_grant0", req_rdy, 4'b0100);
    step();
    req_vld = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("split_a_vld", a_vld, (c == 1));
      chk("split_b_vld", b_vld, 1'b1);
      chk("split_b_data", b_data, 4'd5);
      chk("split_no_grant", req_rdy, 4'h0);
      step();
    end
    b_rdy = 1'b1; #1;
    chk("split_grant1", req_rdy, 4'b0010);
    chk("split_b_data_last", b_data, 4'd5);
    step();
    req_vld = 4'h0; #1;
    chk("split_next_a", a_data, 4'd6);
    chk("split_rsp_vld", rsp_vld, 4'b0100);
    chk("split_rsp_data", rsp_data, 5'd8);
    step();
    drain(6);

    // Tag FIFO full: four grants then none until the head owner accepts.
    req_a = 16'h4321; req_b = 16'h8765; req_vld = 4'hF; rsp_rdy = 4'h0;
    exp_gnt = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("full_grant", req_rdy, exp_gnt[c]);
      if (c >= 2) chk("full_rsp_vld", rsp_vld, 4'b0100);
      step();
    end
    rsp_rdy = 4'b1011;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_sum_rdy", sum_rdy, 1'b0);
      chk("bp_rsp_vld", rsp_vld, 4'b0100);
      chk("bp_rsp_data", rsp_data, 5'd10);
      chk("bp_no_grant", req_rdy, 4'h0);
      step();
    end
    rsp_rdy = 4'b0100; #1;
    chk("full_pop_rdy", sum_rdy, 1'b1);
    chk("full_pop_no_grant", req_rdy, 4'h0);
    step(); #1;
    chk("full_regrant", req_rdy, 4'b0100);
    chk("full_next_head", rsp_vld, 4'b1000);
    chk("full_next_data", rsp_data, 5'd12);
    chk("full_next_stall", sum_rdy, 1'b0);
    step(); #1;
    chk("full_again", req_rdy, 4'h0);
    drain(12);

    // Reset in the middle of an issue with a done and b pending.
    req_a = 16'h0; req_b = 16'h0; req_a[11:8] = 4'd1; req_b[11:8] = 4'd1;
    req_vld = 4'b0100; a_rdy = 1'b1; b_rdy = 1'b0; #1;
    chk("mid_grant", req_rdy, 4'b0100);
    step();
    req_vld = 4'h0;
    step(); #1;
    chk("mid_pending", {a_vld, b_vld}, 2'b01);
    rst = 1'b1; #1;
    chk("mid_in_rst", {a_vld, b_vld, req_rdy, sum_rdy, rsp_vld}, 11'h0);
    step();
    rst = 1'b0; b_rdy = 1'b1; #1;
    chk("mid_after_rst", {a_vld, b_vld, req_rdy, sum_rdy, rsp_vld}, 11'h0);
    step();
    req_vld = 4'hF; #1;
    chk("mid_first_winner", req_rdy, 4'b0001);
    step();
    drain(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
